ex_operand_stage: RTL and testbench

Pipeline register between decode and the EX-stage ALU. It accepts one decoded instruction per cycle over a valid/ready handshake and selects the ALU operands (rj or pc for `a`, rk or immediate for `b`). It resolves read-after-write hazards against the MEM and WB stages, then presents registered `alu_ctrl`/`a`/`b` plus writeback tags to the EX stage. Single-entry buffering; flush discards the held instruction.

---
 rtl/ex_operand_stage_if.sv | 49 ++++
 rtl/ex_operand_stage.sv | 135 +++++++++++++
 tb/tb_ex_operand_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Decode-to-EX operand stage bus: upstream handshake and payload, MEM/WB forward
// buses, flush, and the registered downstream payload.
interface ex_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_rj_val;
  logic [XLEN-1:0]   in_rk_val;
  logic [XLEN-1:0]   in_imm;
  logic [4:0]        in_rj;
  logic [4:0]        in_rk;
  logic [4:0]        in_rd;
  logic              in_sel_a;
  logic              in_sel_b;
  logic [CTRL_W-1:0] in_alu_ctrl;
  logic              in_rd_we;
  logic              mem_we;
  logic [4:0]        mem_rd;
  logic [XLEN-1:0]   mem_res;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_res;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_a;
  logic [XLEN-1:0]   out_b;
  logic [CTRL_W-1:0] out_alu_ctrl;
  logic [4:0]        out_rd;
  logic              out_rd_we;

  modport master (
    output flush, in_valid, in_pc, in_rj_val, in_rk_val, in_imm, in_rj, in_rk, in_rd,
           in_sel_a, in_sel_b, in_alu_ctrl, in_rd_we, mem_we, mem_rd, mem_res,
           wb_we, wb_rd, wb_res, out_ready,
    input  in_ready, out_valid, out_pc, out_a, out_b, out_alu_ctrl, out_rd, out_rd_we
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rj_val, in_rk_val, in_imm, in_rj, in_rk, in_rd,
           in_sel_a, in_sel_b, in_alu_ctrl, in_rd_we, mem_we, mem_rd, mem_res,
           wb_we, wb_rd, wb_res, out_ready,
    output in_ready, out_valid, out_pc, out_a, out_b, out_alu_ctrl, out_rd, out_rd_we
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Single-entry decode->EX register with operand select and RAW handling.
// EX_FWD_EN: forward from MEM/WB (and refresh held operands); otherwise stall on hazards.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  ex_operand_stage_if.slave bus
);

  function automatic logic fwd_hit(input logic [4:0] src, input logic we, input logic [4:0] rd);
    return we && (rd == src) && (src != 5'd0);
  endfunction

`ifdef EX_FWD_EN
  function automatic logic signed [XLEN-1:0] fwd_val(
    input logic [4:0]             src,
    input logic signed [XLEN-1:0] rf_val,
    input logic                   m_we,
    input logic [4:0]             m_rd,
    input logic signed [XLEN-1:0] m_res,
    input logic                   w_we,
    input logic [4:0]             w_rd,
    input logic signed [XLEN-1:0] w_res
  );
    if (fwd_hit(src, m_we, m_rd))      return m_res;
    else if (fwd_hit(src, w_we, w_rd)) return w_res;
    else                               return rf_val;
  endfunction
`endif

  logic                     vld_p1;
  logic signed [XLEN-1:0]   pc_p1;
  logic signed [XLEN-1:0]   a_p1;
  logic signed [XLEN-1:0]   b_p1;
  logic [CTRL_W-1:0]        ctrl_p1;
  logic [4:0]               rd_p1;
  logic                     rd_we_p1;

  logic                     hazard;
  logic                     capture;
  logic signed [XLEN-1:0]   rj_src;
  logic signed [XLEN-1:0]   rk_src;
  logic signed [XLEN-1:0]   a_nxt;
  logic signed [XLEN-1:0]   b_nxt;

`ifdef EX_FWD_EN
  logic [4:0]               rj_p1;
  logic [4:0]               rk_p1;
  logic                     sel_a_p1;
  logic                     sel_b_p1;

  assign hazard = 1'b0;
  assign rj_src = fwd_val(bus.in_rj, bus.in_rj_val, bus.mem_we, bus.mem_rd, bus.mem_res,
                          bus.wb_we, bus.wb_rd, bus.wb_res);
  assign rk_src = fwd_val(bus.in_rk, bus.in_rk_val, bus.mem_we, bus.mem_rd, bus.mem_res,
                          bus.wb_we, bus.wb_rd, bus.wb_res);
`else
  logic                     unused_res;

  // Result buses are only consumed when forwarding is compiled in.
  assign unused_res = ^{bus.mem_res, bus.wb_res};
  assign hazard = (!bus.in_sel_a && (fwd_hit(bus.in_rj, bus.mem_we, bus.mem_rd) ||
                                     fwd_hit(bus.in_rj, bus.wb_we,  bus.wb_rd))) ||
                  (!bus.in_sel_b && (fwd_hit(bus.in_rk, bus.mem_we, bus.mem_rd) ||
                                     fwd_hit(bus.in_rk, bus.wb_we,  bus.wb_rd)));
  assign rj_src = bus.in_rj_val;
  assign rk_src = bus.in_rk_val;
`endif

  assign a_nxt        = bus.in_sel_a ? bus.in_pc  : rj_src;
  assign b_nxt        = bus.in_sel_b ? bus.in_imm : rk_src;
  assign bus.in_ready = !bus.flush && !hazard && (!vld_p1 || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;

  // ---- stage p1: operand register presented to EX ----
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      a_p1     <= '0;
      b_p1     <= '0;
      ctrl_p1  <= '0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
`ifdef EX_FWD_EN
      rj_p1    <= '0;
      rk_p1    <= '0;
      sel_a_p1 <= 1'b0;
      sel_b_p1 <= 1'b0;
`endif
    end else begin
      if (bus.flush) begin
        vld_p1 <= 1'b0;
      end else if (capture) begin
        vld_p1   <= 1'b1;
        pc_p1    <= bus.in_pc;
        a_p1     <= a_nxt;
        b_p1     <= b_nxt;
        ctrl_p1  <= bus.in_alu_ctrl;
        rd_p1    <= bus.in_rd;
        rd_we_p1 <= bus.in_rd_we;
`ifdef EX_FWD_EN
        rj_p1    <= bus.in_rj;
        rk_p1    <= bus.in_rk;
        sel_a_p1 <= bus.in_sel_a;
        sel_b_p1 <= bus.in_sel_b;
`endif
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
`ifdef EX_FWD_EN
      // A stalled entry keeps picking up producers that retire while it waits.
      else if (vld_p1) begin
        if (!sel_a_p1)
          a_p1 <= fwd_val(rj_p1, a_p1, bus.mem_we, bus.mem_rd, bus.mem_res,
                          bus.wb_we, bus.wb_rd, bus.wb_res);
        if (!sel_b_p1)
          b_p1 <= fwd_val(rk_p1, b_p1, bus.mem_we, bus.mem_rd, bus.mem_res,
                          bus.wb_we, bus.wb_rd, bus.wb_res);
      end
`endif
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.out_pc       = pc_p1;
  assign bus.out_a        = a_p1;
  assign bus.out_b        = b_p1;
  assign bus.out_alu_ctrl = ctrl_p1;
  assign bus.out_rd       = rd_p1;
  assign bus.out_rd_we    = rd_we_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage (both EX_FWD_EN builds).
module tb_ex_operand_stage;
  logic clk;
  logic aresetn;
  int   n_tests;
  int   n_fail;

  ex_operand_stage_if #(.XLEN(32), .CTRL_W(4)) bus ();

  ex_operand_stage #(.XLEN(32), .CTRL_W(4)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_pc       = '0;
    bus.in_rj_val   = '0;
    bus.in_rk_val   = '0;
    bus.in_imm      = '0;
    bus.in_rj       = '0;
    bus.in_rk       = '0;
    bus.in_rd       = '0;
    bus.in_sel_a    = 1'b0;
    bus.in_sel_b    = 1'b0;
    bus.in_alu_ctrl = '0;
    bus.in_rd_we    = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_res     = '0;
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_res      = '0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.out_ready = 1'b1;
    drive_idle();
    repeat (2) tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", bus.out_valid); end
    n_tests++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %0h want 0", bus.out_pc); end
    n_tests++; if (bus.out_a !== 32'h0) begin n_fail++; $display("FAIL rst_a: got %0h want 0", bus.out_a); end
    n_tests++; if (bus.out_b !== 32'h0) begin n_fail++; $display("FAIL rst_b: got %0h want 0", bus.out_b); end
    n_tests++; if (bus.out_alu_ctrl !== 4'h0) begin n_fail++; $display("FAIL rst_ctrl: got %0h want 0", bus.out_alu_ctrl); end
    n_tests++; if (bus.out_rd !== 5'h0) begin n_fail++; $display("FAIL rst_rd: got %0h want 0", bus.out_rd); end
    n_tests++; if (bus.out_rd_we !== 1'b0) begin n_fail++; $display("FAIL rst_rd_we: got %0h want 0", bus.out_rd_we); end
    @(negedge clk);
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_idle();
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_sel_a    = 1'b0;
    bus.in_sel_b    = 1'b1;
    bus.in_rj       = 5'd1;
    bus.in_rj_val   = 32'h10;
    bus.in_imm      = 32'h5;
    bus.in_alu_ctrl = 4'h1;
    bus.in_pc       = 32'h40;
    bus.in_rd       = 5'd2;
    bus.in_rd_we    = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0h want 1", bus.in_ready); end
    tick();
    drive_idle();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0h want 1", bus.out_valid); end
    n_tests++; if (bus.out_a !== 32'h10) begin n_fail++; $display("FAIL basic_a: got %0h want 10", bus.out_a); end
    n_tests++; if (bus.out_b !== 32'h5) begin n_fail++; $display("FAIL basic_b: got %0h want 5", bus.out_b); end
    n_tests++; if (bus.out_alu_ctrl !== 4'h1) begin n_fail++; $display("FAIL basic_ctrl: got %0h want 1", bus.out_alu_ctrl); end
    n_tests++; if (bus.out_pc !== 32'h40) begin n_fail++; $display("FAIL basic_pc: got %0h want 40", bus.out_pc); end
    n_tests++; if (bus.out_rd !== 5'd2 || bus.out_rd_we !== 1'b1) begin n_fail++; $display("FAIL basic_rd: got %0h/%0h want 2/1", bus.out_rd, bus.out_rd_we); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0h want 0", bus.out_valid); end
  endtask

`ifdef EX_FWD_EN
  task automatic test_forward();
    drive_idle();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel_b  = 1'b1;
    bus.in_rj     = 5'd3;
    bus.in_rj_val = 32'h11;
    bus.mem_we = 1'b1; bus.mem_rd = 5'd3; bus.mem_res = 32'hAA;
    bus.wb_we  = 1'b1; bus.wb_rd  = 5'd3; bus.wb_res  = 32'hBB;
    tick();
    n_tests++; if (bus.out_a !== 32'hAA) begin n_fail++; $display("FAIL fwd_mem_prio: got %0h want aa", bus.out_a); end
    bus.in_rj = 5'd0; bus.in_rj_val = 32'h22; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
    tick();
    n_tests++; if (bus.out_a !== 32'h22) begin n_fail++; $display("FAIL fwd_r0: got %0h want 22", bus.out_a); end
    bus.in_rj = 5'd3; bus.in_rj_val = 32'h33; bus.mem_we = 1'b0; bus.mem_rd = 5'd3; bus.wb_rd = 5'd3;
    tick();
    n_tests++; if (bus.out_a !== 32'hBB) begin n_fail++; $display("FAIL fwd_wb: got %0h want bb", bus.out_a); end
    bus.in_sel_b = 1'b0; bus.in_rk = 5'd9; bus.in_rk_val = 32'h44;
    bus.mem_we = 1'b1; bus.mem_rd = 5'd9; bus.mem_res = 32'hCC; bus.wb_we = 1'b0;
    tick();
    n_tests++; if (bus.out_b !== 32'hCC) begin n_fail++; $display("FAIL fwd_rk_mem: got %0h want cc", bus.out_b); end
    n_tests++; if (bus.out_a !== 32'h33) begin n_fail++; $display("FAIL fwd_rj_rf: got %0h want 33", bus.out_a); end
    drive_idle();
    tick();
  endtask
`else
  task automatic test_hazard();
    drive_idle();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel_b  = 1'b1;
    bus.in_rj     = 5'd5;
    bus.in_rj_val = 32'h77;
    bus.in_imm    = 32'h9;
    bus.in_pc     = 32'h60;
    bus.mem_we = 1'b1; bus.mem_rd = 5'd5; bus.mem_res = 32'hEE;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL haz_c1_ready: got %0h want 0", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL haz_c1_valid: got %0h want 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL haz_c2_ready: got %0h want 0", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL haz_c2_valid: got %0h want 0", bus.out_valid); end
    bus.mem_we = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL haz_clear_ready: got %0h want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h77) begin n_fail++; $display("FAIL haz_capture: got %0h/%0h want 1/77", bus.out_valid, bus.out_a); end
    n_tests++; if (bus.out_pc !== 32'h60) begin n_fail++; $display("FAIL haz_pc: got %0h want 60", bus.out_pc); end
    tick();
    bus.in_sel_b = 1'b0; bus.in_rk = 5'd6; bus.in_rj = 5'd0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd6;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL haz_rk_wb: got %0h want 0", bus.in_ready); end
    bus.in_sel_b = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL haz_rk_unused: got %0h want 1", bus.in_ready); end
    bus.wb_we = 1'b0; bus.mem_we = 1'b1; bus.mem_rd = 5'd0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL haz_r0: got %0h want 1", bus.in_ready); end
    drive_idle();
    tick();
  endtask
`endif

  task automatic test_hold();
    logic [31:0] exp_b;
`ifdef EX_FWD_EN
    exp_b = 32'h1234;
`else
    exp_b = 32'h55;
`endif
    drive_idle();
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_sel_a    = 1'b1;
    bus.in_sel_b    = 1'b0;
    bus.in_pc       = 32'h80;
    bus.in_rk       = 5'd7;
    bus.in_rk_val   = 32'h55;
    bus.in_alu_ctrl = 4'h3;
    bus.in_rd       = 5'd4;
    bus.in_rd_we    = 1'b1;
    tick();
    drive_idle();
    bus.out_ready = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h80 || bus.out_b !== 32'h55) begin n_fail++; $display("FAIL hold_load: got %0h/%0h/%0h want 1/80/55", bus.out_valid, bus.out_a, bus.out_b); end
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_c1_ready: got %0h want 0", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_b !== 32'h55) begin n_fail++; $display("FAIL hold_c1_b: got %0h want 55", bus.out_b); end
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_res = 32'h1234;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_c2_ready: got %0h want 0", bus.in_ready); end
    tick();
    bus.wb_we = 1'b0;
    n_tests++; if (bus.out_b !== exp_b) begin n_fail++; $display("FAIL hold_refresh_b: got %0h want %0h", bus.out_b, exp_b); end
    n_tests++; if (bus.out_a !== 32'h80 || bus.out_pc !== 32'h80) begin n_fail++; $display("FAIL hold_a_pc: got %0h/%0h want 80/80", bus.out_a, bus.out_pc); end
    n_tests++; if (bus.out_alu_ctrl !== 4'h3 || bus.out_rd !== 5'd4 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ctrl: got %0h/%0h/%0h want 3/4/1", bus.out_alu_ctrl, bus.out_rd, bus.out_valid); end
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_c3_ready: got %0h want 0", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_b !== exp_b || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_c3_b: got %0h/%0h want %0h/1", bus.out_b, bus.out_valid, exp_b); end
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %0h want 1", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got %0h want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid    = 1'b1;
      bus.in_sel_a    = 1'b0;
      bus.in_sel_b    = 1'b1;
      bus.in_pc       = 32'h100 + 32'(4 * i);
      bus.in_rj       = 5'(i + 1);
      bus.in_rj_val   = 32'h1000 + 32'(i);
      bus.in_imm      = 32'h20 + 32'(i);
      bus.in_alu_ctrl = 4'(i);
      bus.in_rd       = 5'(i + 8);
      #1;
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0h want 1", i, bus.in_ready); end
      tick();
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %0h/%0h want 1/%0h", i, bus.out_valid, bus.out_pc, 32'h100 + 32'(4 * i)); end
      n_tests++; if (bus.out_a !== 32'h1000 + 32'(i) || bus.out_b !== 32'h20 + 32'(i)) begin n_fail++; $display("FAIL b2b_ab[%0d]: got %0h/%0h", i, bus.out_a, bus.out_b); end
    end
    drive_idle();
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    drive_idle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel_a  = 1'b1;
    bus.in_sel_b  = 1'b1;
    bus.in_pc     = 32'h200;
    tick();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin n_fail++; $display("FAIL flush_load: got %0h/%0h want 1/200", bus.out_valid, bus.out_pc); end
    bus.flush = 1'b1;
    bus.in_pc = 32'h300;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0h want 0", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %0h want 0", bus.out_valid); end
    drive_idle();
    bus.out_ready = 1'b1;
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_not_consumed: got %0h want 0", bus.out_valid); end
  endtask

  task automatic test_reset_stall();
    drive_idle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel_a  = 1'b1;
    bus.in_pc     = 32'h400;
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rs_load: got %0h want 1", bus.out_valid); end
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rs_stall_ready: got %0h want 0", bus.in_ready); end
    #2;
    aresetn = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rs_async: got %0h/%0h want 0/0", bus.out_valid, bus.out_pc); end
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rs_ready: got %0h want 1", bus.in_ready); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_empty: got %0h want 0", bus.out_valid); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
`ifdef EX_FWD_EN
    test_forward();
`else
    test_hazard();
`endif
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
